// File: rtl/selector.sv
// Shared decode/commit package: decoder exception selector, CP0 register
// numbers, ExcCode values and the exception unit state encoding.
package selector;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        SYSCALL   = 2'd1,
        RESERVERD = 2'd2
    } exc_chk_t;

    localparam logic [4:0] CP0_COUNT  = 5'd9;
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } exc_state_t;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 storage: Count, Status.EXL, Cause.{BD,ExcCode} and EPC, with masked
// MTC0 writes and an unbypassed MFC0 read port.
module cp0_regfile
    import selector::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        exc_take,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret_take,
    output logic        exl,
    output logic [31:0] epc
);

    logic [31:0] count_r;
    logic        exl_r;
    logic        bd_r;
    logic [4:0]  code_r;
    logic [31:0] epc_r;

    // CP0 state update: exception, then ERET, then MTC0; Count always ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 32'd0;
            exl_r   <= 1'b0;
            bd_r    <= 1'b0;
            code_r  <= 5'd0;
            epc_r   <= 32'd0;
        end else begin
            count_r <= (wr_en && (waddr == CP0_COUNT)) ? wdata : (count_r + 32'd1);
            if (exc_take) begin
                // A nested exception keeps the original return point.
                if (!exl_r) begin
                    epc_r <= epc_of(exc_pc, exc_bd);
                    bd_r  <= exc_bd;
                end
                code_r <= exc_code;
                exl_r  <= 1'b1;
            end else if (eret_take) begin
                exl_r <= 1'b0;
            end else if (wr_en) begin
                case (waddr)
                    CP0_STATUS: exl_r <= wdata[1];
                    CP0_EPC:    epc_r <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    // MFC0 read mux.
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            CP0_COUNT:  rdata = count_r;
            CP0_STATUS: rdata = {30'd0, exl_r, 1'b0};
            CP0_CAUSE:  rdata = {bd_r, 24'd0, code_r, 2'd0};
            CP0_EPC:    rdata = epc_r;
            default:    rdata = 32'd0;
        endcase
    end

    assign exl = exl_r;
    assign epc = epc_r;

endmodule

// File: rtl/exception_unit.sv
// Commit-side exception prioritisation, pipeline flush and fetch redirect
// handshake around the CP0 register file.
module exception_unit
    import selector::*;
#(
    parameter logic [31:0] VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  exc_chk_t    commit_exc,
    input  logic        commit_ovf,
    input  logic        commit_eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        status_exl
);

    exc_state_t  state_r;
    logic        commit_ready_r;
    logic        flush_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    logic        accept_s;
    logic        exc_take_s;
    logic        eret_take_s;
    logic        wr_en_s;
    logic [4:0]  exc_code_s;
    logic        exl_s;
    logic [31:0] epc_s;

    // Event prioritisation for the instruction accepted this cycle.
    always_comb begin
        accept_s    = commit_valid && (state_r == ST_RUN);
        exc_take_s  = 1'b0;
        eret_take_s = 1'b0;
        wr_en_s     = 1'b0;
        exc_code_s  = 5'd0;
        if (accept_s) begin
            case (commit_exc)
                RESERVERD: begin
                    exc_take_s = 1'b1;
                    exc_code_s = EXC_RI;
                end
                SYSCALL: begin
                    exc_take_s = 1'b1;
                    exc_code_s = EXC_SYS;
                end
                default: begin
                    if (commit_ovf) begin
                        exc_take_s = 1'b1;
                        exc_code_s = EXC_OV;
                    end else if (commit_eret) begin
                        // ERET outside exception level is an illegal instruction.
                        if (exl_s) begin
                            eret_take_s = 1'b1;
                        end else begin
                            exc_take_s = 1'b1;
                            exc_code_s = EXC_RI;
                        end
                    end else begin
                        wr_en_s = cp0_we;
                    end
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Redirect FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_RUN;
            commit_ready_r   <= 1'b1;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_take_s || eret_take_s) begin
                        state_r          <= ST_REDIRECT;
                        commit_ready_r   <= 1'b0;
                        flush_r          <= 1'b1;
                        redirect_valid_r <= 1'b1;
                        redirect_pc_r    <= exc_take_s ? VECTOR : epc_s;
                    end else begin
                        flush_r <= 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    flush_r <= 1'b0;
                    if (redirect_ready) begin
                        state_r          <= ST_RUN;
                        commit_ready_r   <= 1'b1;
                        redirect_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r          <= ST_RUN;
                    commit_ready_r   <= 1'b1;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                end
            endcase
        end
    end

    cp0_regfile u_cp0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en_s),
        .waddr     (cp0_waddr),
        .wdata     (cp0_wdata),
        .raddr     (cp0_raddr),
        .rdata     (cp0_rdata),
        .exc_take  (exc_take_s),
        .exc_code  (exc_code_s),
        .exc_pc    (commit_pc),
        .exc_bd    (commit_bd),
        .eret_take (eret_take_s),
        .exl       (exl_s),
        .epc       (epc_s)
    );

    assign commit_ready   = commit_ready_r;
    assign flush          = flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign status_exl     = exl_s;

endmodule

// File: doc/exception_unit.md
# exception_unit

Commit-side exception and CP0 control for the pipeline. It consumes the per-instruction `exc_chk` selector that the decoders produce, plus overflow and ERET indications, at the commit point. It records EPC, Cause and Status, and flushes the pipeline. It then holds a redirect request, with either the exception vector or the EPC, until fetch accepts it. It also provides the CP0 register file used by MTC0 and MFC0.

## Interface
Parameters:
- `VECTOR`, 32'h8000_0180, general exception entry PC.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  1  an instruction is presented at commit.
- `commit_ready`  out  1  the unit accepts commit this cycle.
- `commit_pc`  in  32  PC of the committing instruction.
- `commit_bd`  in  1  the instruction is in a branch delay slot.
- `commit_exc`  in  `selector::exc_chk_t`  decoder exception check: NONE, SYSCALL or RESERVERD.
- `commit_ovf`  in  1  the ALU signalled signed overflow.
- `commit_eret`  in  1  the instruction is ERET.
- `cp0_we`  in  1  MTC0 write enable, qualified by commit handshake.
- `cp0_waddr` / `cp0_raddr`  in  5  CP0 register number.
- `cp0_wdata`  in  32  MTC0 data.
- `cp0_rdata`  out  32  MFC0 data, combinational.
- `flush`  out  1  one-cycle kill of all younger stages.
- `redirect_valid`  out  1  a fetch redirect is pending.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `redirect_pc`  out  32  target PC of the redirect.
- `status_exl`  out  1  current Status.EXL.

## Operation
- Registers: Count(9), Status(12, only EXL bit 1 is writable, other bits read 0), Cause(13, BD bit 31, ExcCode bits 6:2, read-only), EPC(14). Other addresses read 0 and ignore writes.
- Event priority at an accepted commit: RESERVERD (ExcCode 10), then SYSCALL (8), then overflow with `commit_exc`=NONE (12), then ERET, then MTC0.
- On an exception event:
  - If EXL=0: EPC = `commit_bd` ? `commit_pc`−4 : `commit_pc`, and Cause.BD = `commit_bd`.
  - If EXL=1: EPC and BD are unchanged.
  - In both cases ExcCode is written, EXL is set to 1, and the redirect target is `VECTOR`.
- ERET with EXL=1: clear EXL; the redirect target is EPC. ERET with EXL=0 is treated as RESERVERD.
- MTC0 is applied only when no exception or ERET occurs in the same commit.
- Count increments by 1 every cycle (wraps 32'hFFFF_FFFF to 0). An MTC0 to Count that cycle wins over the increment.
- Subtraction for EPC is modulo 2^32.
- FSM:
  - RUN: `commit_ready`=1. An exception or ERET at handshake moves to REDIRECT.
  - REDIRECT: `commit_ready`=0 and commit inputs are ignored. `redirect_valid`=1. `redirect_valid & redirect_ready` returns to RUN.

## Timing
- Reset values: all CP0 registers 0; state RUN; `flush`=0; `redirect_valid`=0; `redirect_pc`=0; `commit_ready`=1.
- Reset asserted mid-REDIRECT abandons the redirect immediately.
- Event accepted in cycle T:
  - CP0 updates are visible from T+1.
  - `flush`=1 only in T+1.
  - `redirect_valid` rises in T+1.
  - `redirect_pc` is registered in T and stable until the handshake.
- The redirect handshake completes in the cycle where `redirect_valid & redirect_ready`=1. Fastest case is T+1, giving RUN and `commit_ready`=1 in T+2.
- `cp0_rdata` reflects register state before this cycle's write (no bypass).
- `commit_valid` with `commit_ready`=0 has no effect; the upstream stage holds.

## Structure
- Add to the shared package:
  - CP0 register numbers (COUNT, STATUS, CAUSE, EPC);
  - ExcCode constants (EXC_SYS=8, EXC_RI=10, EXC_OV=12);
  - the FSM state enum.
- `exc_chk_t` remains in `selector`.
- One sub-module: `cp0_regfile` (storage, Count increment, read mux, masked writes). The FSM and prioritisation stay in `exception_unit`.

## Test plan
- SYSCALL at pc 32'h0040_0020, bd=0, in cycle T:
  - T+1: `flush`=1, `redirect_valid`=1, `redirect_pc`=32'h8000_0180;
  - EPC=32'h0040_0020, Cause.ExcCode=8, EXL=1.
- RESERVERD at pc 32'h0040_0104, bd=1 → EPC=32'h0040_0100, Cause=32'h8000_0028.
- EPC=32'h0040_0024 with EXL=1, then ERET → `redirect_pc`=32'h0040_0024, EXL=0, one `flush` pulse.
- `redirect_ready` low for 3 cycles → `redirect_valid` and `redirect_pc` stay stable, `commit_ready`=0, and a commit presented meanwhile changes nothing.
- Overflow while EXL=1 at pc 32'h0040_0200 → EPC unchanged, ExcCode=12. Then an MTC0 to Count with 32'hFFFF_FFFF → reads 32'h0000_0000 two cycles later.
- `reset_n` pulsed low during REDIRECT → `redirect_valid`=0, `flush`=0, and all CP0 registers 0 asynchronously.
